// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared state encoding and gap-timer width for updown_driver
package updown_pkg;

    localparam int GAP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        PACE = 2'd2
    } state_t;

endpackage

// File: rtl/pace_timer.sv
// rtl/pace_timer.sv - load/decrement gap counter; expired flags the last idle cycle of a gap
module pace_timer
    import updown_pkg::*;
#(
    parameter int GAP = 3
) (
    input  logic clk,
    input  logic artsn,
    input  logic load,
    output logic expired
);

    logic [GAP_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge artsn) begin
        if (!artsn) begin
            count <= '0;
        end else if (load) begin
            count <= GAP_CNT_W'(GAP);
        end else if (count != '0) begin
            count <= count - GAP_CNT_W'(1);
        end
    end

    assign expired = (count == GAP_CNT_W'(1));

endmodule

// File: rtl/updown_driver.sv
// rtl/updown_driver.sv - drives up/down strobes until a mirrored counter reaches target
// Optional strobe pacing compiled in with UPDOWN_DRIVER_PACE_EN.
module updown_driver
    import updown_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int GAP   = 3
) (
    input  logic             clk,
    input  logic             artsn,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    output logic             target_ready,
    output logic             up,
    output logic             down,
    output logic [WIDTH-1:0] mirror_value,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] mirror_next;
    logic [WIDTH-1:0] cmp_tgt;
    logic             go_up;
    logic             go_down;
    logic             at_target;
    logic             issue;
    logic             up_d;
    logic             down_d;
    logic             done_d;

`ifdef UPDOWN_DRIVER_PACE_EN
    logic load_gap;
    logic expired;

    pace_timer #(.GAP(GAP)) u_pace_timer (
        .clk     (clk),
        .artsn   (artsn),
        .load    (load_gap),
        .expired (expired)
    );
`else
    logic gap_unused;
    assign gap_unused = ^GAP_CNT_W'(GAP);
`endif

    // Value the counter will hold after this edge; equals mirror_value whenever no strobe is high.
    always_comb begin
        mirror_next = mirror_value;
        if (up) begin
            mirror_next = mirror_value + WIDTH'(1);
        end else if (down) begin
            mirror_next = mirror_value - WIDTH'(1);
        end
    end

    assign cmp_tgt   = (state == IDLE) ? target : tgt_q;
    assign go_up     = (cmp_tgt > mirror_next);
    assign go_down   = (cmp_tgt < mirror_next);
    assign at_target = (cmp_tgt == mirror_next);

    always_ff @(posedge clk or negedge artsn) begin
        if (!artsn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (target_valid && !at_target) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (at_target) begin
                    state_d = IDLE;
                end else begin
`ifdef UPDOWN_DRIVER_PACE_EN
                    state_d = PACE;
`else
                    state_d = STEP;
`endif
                end
            end
`ifdef UPDOWN_DRIVER_PACE_EN
            PACE: begin
                if (expired) begin
                    state_d = STEP;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        done_d = 1'b0;
`ifdef UPDOWN_DRIVER_PACE_EN
        load_gap = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (target_valid) begin
                    done_d = at_target;
                    issue  = !at_target;
                end
            end
            STEP: begin
                if (at_target) begin
                    done_d = 1'b1;
                end else begin
`ifdef UPDOWN_DRIVER_PACE_EN
                    load_gap = 1'b1;
`else
                    issue = 1'b1;
`endif
                end
            end
`ifdef UPDOWN_DRIVER_PACE_EN
            PACE: begin
                issue = expired;
            end
`endif
            default: begin
                issue  = 1'b0;
                done_d = 1'b0;
            end
        endcase
        up_d   = issue & go_up;
        down_d = issue & go_down;
    end

    always_ff @(posedge clk or negedge artsn) begin
        if (!artsn) begin
            up           <= 1'b0;
            down         <= 1'b0;
            done         <= 1'b0;
            mirror_value <= '0;
            tgt_q        <= '0;
        end else begin
            up           <= up_d;
            down         <= down_d;
            done         <= done_d;
            mirror_value <= mirror_next;
            if (state == IDLE && target_valid) begin
                tgt_q <= target;
            end
        end
    end

    assign target_ready = (state == IDLE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_updown_driver.sv
// tb/tb_updown_driver.sv - randomized self-checking bench for updown_driver (pacing follows UPDOWN_DRIVER_PACE_EN)
module tb_updown_driver;

    localparam int W = 10;
`ifdef UPDOWN_DRIVER_PACE_EN
    localparam int G = 3;
`else
    localparam int G = 0;
`endif

    logic         clk = 1'b0;
    logic         artsn;
    logic [W-1:0] target;
    logic         target_valid;
    logic         target_ready;
    logic         up;
    logic         down;
    logic [W-1:0] mirror_value;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    int model_mirror = 0;
    bit pending = 0;

    updown_driver #(.WIDTH(W), .GAP(3)) dut (
        .clk          (clk),
        .artsn        (artsn),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .up           (up),
        .down         (down),
        .mirror_value (mirror_value),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic bit strobe_at(input int c, input int n);
        if (n == 0) return 1'b0;
        if (((c - 1) % (G + 1)) != 0) return 1'b0;
        return ((c - 1) / (G + 1)) < n;
    endfunction

    function automatic int done_cycle(input int n);
        return (n == 0) ? 1 : (n - 1) * (G + 1) + 2;
    endfunction

    task automatic do_move(input int t, input bit inject, input bit chain, input int next_t);
        int n;
        int dcyc;
        int last;
        int exp_m;
        bit dir_up;
        bit su;
        bit act;
        n      = (t > model_mirror) ? t - model_mirror : model_mirror - t;
        dir_up = (t > model_mirror);
        dcyc   = done_cycle(n);
        exp_m  = model_mirror;
        if (!pending) begin
            @(negedge clk);
            checks++;
            if (target_ready !== 1'b1)
                $display("FAIL accept_ready target=%0d got=%b exp=1", t, target_ready);
            target       = W'(t);
            target_valid = 1'b1;
        end
        pending = 0;
        @(posedge clk);
        #1 target_valid = 1'b0;
        last = chain ? dcyc : dcyc + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            su  = strobe_at(c, n);
            act = (c < dcyc) && (n > 0);
            checks++;
            if (up !== (su && dir_up)) begin
                failures++;
                $display("FAIL up target=%0d cycle=%0d got=%b exp=%b", t, c, up, su && dir_up);
            end
            checks++;
            if (down !== (su && !dir_up)) begin
                failures++;
                $display("FAIL down target=%0d cycle=%0d got=%b exp=%b", t, c, down, su && !dir_up);
            end
            checks++;
            if (done !== (c == dcyc)) begin
                failures++;
                $display("FAIL done target=%0d cycle=%0d got=%b exp=%b", t, c, done, c == dcyc);
            end
            checks++;
            if (busy !== act) begin
                failures++;
                $display("FAIL busy target=%0d cycle=%0d got=%b exp=%b", t, c, busy, act);
            end
            checks++;
            if (target_ready !== !act) begin
                failures++;
                $display("FAIL ready target=%0d cycle=%0d got=%b exp=%b", t, c, target_ready, !act);
            end
            checks++;
            if (mirror_value !== exp_m[W-1:0]) begin
                failures++;
                $display("FAIL mirror target=%0d cycle=%0d got=%0d exp=%0d", t, c, mirror_value, exp_m);
            end
            if (su) exp_m = dir_up ? exp_m + 1 : exp_m - 1;
            if (inject && c == 2) begin
                target       = W'(900);
                target_valid = 1'b1;
            end else if (inject && c == 3) begin
                target_valid = 1'b0;
            end
            if (chain && c == dcyc) begin
                target       = W'(next_t);
                target_valid = 1'b1;
                pending      = 1;
            end
        end
        model_mirror = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (up !== 1'b0 || down !== 1'b0) begin
            failures++;
            $display("FAIL %s_strobes got=%b%b exp=00", tag, up, down);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_done got=%b%b exp=00", tag, busy, done);
        end
        checks++;
        if (mirror_value !== '0) begin
            failures++;
            $display("FAIL %s_mirror got=%0d exp=0", tag, mirror_value);
        end
        checks++;
        if (target_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready got=%b exp=1", tag, target_ready);
        end
    endtask

    task automatic test_reset();
        artsn        = 1'b0;
        target_valid = 1'b0;
        target       = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        artsn = 1'b1;
        model_mirror = 0;
    endtask

    task automatic test_basic();
        do_move(5, 0, 0, 0);
        do_move(2, 0, 0, 0);
        do_move(2, 0, 0, 0);
    endtask

    task automatic test_ignore();
        do_move(40, 1, 0, 0);
    endtask

    task automatic test_pace();
        do_move(0, 0, 0, 0);
        do_move(3, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_move(9, 0, 1, 4);
        do_move(4, 0, 1, 4);
        do_move(4, 0, 1, 12);
        do_move(12, 0, 0, 0);
    endtask

    task automatic test_random();
        int d;
        int t;
        for (int i = 0; i < 10; i++) begin
            d = int'($urandom_range(0, 24));
            t = ($urandom_range(0, 1) == 1) ? model_mirror + d : model_mirror - d;
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            do_move(t, 0, 0, 0);
        end
    endtask

    task automatic test_boundary();
        do_move(1023, 0, 0, 0);
        do_move(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        target       = W'(1023);
        target_valid = 1'b1;
        @(posedge clk);
        #1 target_valid = 1'b0;
        repeat (4 * (G + 1)) @(negedge clk);
        #2 artsn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        artsn = 1'b1;
        model_mirror = 0;
        do_move(1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_pace();
        test_back_to_back();
        test_random();
        test_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
